clause_loader: RTL

CLAUSE_LOADER -- requirements
Module: clause_loader

---
 rtl/clause_loader.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/clause_loader.sv
// clause_loader: moves clauses between a ready/valid stream and a slotted
// clause array. A load request fills every slot in order from the input
// stream; an unload request reads every slot in order onto the output stream.
//
// Optional build macro: CLAUSE_LOADER_LEN_CHECK_EN
//   defined   -> each loaded clause length is compared with the count of
//                nonzero 2-bit literals; mismatches raise sticky len_err_o
//   undefined -> len_err_o is tied low and no checking logic is built
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   start_load_i              one-cycle request to fill all slots
//   start_unload_i            one-cycle request to read all slots
//   in_valid_i / in_ready_o   input stream handshake
//   in_clause_i / in_len_i    input clause literals / length
//   wr_o / rd_o               one-hot slot write / read strobes
//   clause_o / clause_len_o   write data to the array
//   clause_i                  ORed array readback clause bus
//   clause_len_all_i          packed slot lengths, slot 0 in LSBs
//   out_valid_o / out_ready_i output stream handshake
//   out_clause_o / out_len_o  read-out clause / length
//   busy_o                    high whenever not idle
//   done_o                    one-cycle completion pulse
//   len_err_o                 sticky length-check error
module clause_loader #(
  parameter int unsigned NUM_CLAUSES = 2,
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned WIDTH_C_LEN = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_load_i,
  input  logic                               start_unload_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [NUM_VARS*2-1:0]              in_clause_i,
  input  logic [WIDTH_C_LEN-1:0]             in_len_i,
  output logic [NUM_CLAUSES-1:0]             wr_o,
  output logic [NUM_CLAUSES-1:0]             rd_o,
  output logic [NUM_VARS*2-1:0]              clause_o,
  output logic [WIDTH_C_LEN-1:0]             clause_len_o,
  input  logic [NUM_VARS*2-1:0]              clause_i,
  input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_all_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_VARS*2-1:0]              out_clause_o,
  output logic [WIDTH_C_LEN-1:0]             out_len_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               len_err_o
);

  localparam int unsigned CW    = NUM_VARS * 2;
  localparam int unsigned IDX_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UNLOAD = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_rd_all;      // every slot has been captured
  logic [NUM_CLAUSES-1:0]   r_wr;
  logic [CW-1:0]            r_clause;
  logic [WIDTH_C_LEN-1:0]   r_len;
  logic                     r_out_valid;
  logic [CW-1:0]            r_out_clause;
  logic [WIDTH_C_LEN-1:0]   r_out_len;
  logic                     r_done;

  logic                     w_in_ready;
  logic                     w_beat;
  logic                     w_slot_free;
  logic                     w_rd_go;
  logic [NUM_CLAUSES-1:0]   w_rd;
  logic [NUM_CLAUSES-1:0]   w_onehot;
  logic [WIDTH_C_LEN-1:0]   w_len_sel;

  // One-hot decode of the current slot
  assign w_onehot = NUM_CLAUSES'(1) << r_idx;

  // Output register is free to take a new clause this cycle
  assign w_slot_free = !r_out_valid || out_ready_i;

  // Length field of the current slot from the packed readback bus
  always_comb begin
    w_len_sel = '0;
    for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_len_sel = clause_len_all_i[i*WIDTH_C_LEN +: WIDTH_C_LEN];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and combinational strobes
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_beat      = 1'b0;
    w_rd_go     = 1'b0;
    w_rd        = '0;
    case (r_state)
      ST_IDLE: begin
        // Load has priority when both requests arrive together
        if (start_load_i) begin
          w_state_nxt = ST_LOAD;
        end else if (start_unload_i) begin
          w_state_nxt = ST_UNLOAD;
        end
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        w_beat     = in_valid_i;
        if (in_valid_i && (r_idx == LAST_IDX)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_UNLOAD: begin
        w_rd_go = !r_rd_all && w_slot_free;
        if (w_rd_go) begin
          w_rd = w_onehot;
        end
        // Finish once the final captured clause has drained
        if (r_rd_all && w_slot_free) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Slot counter, write strobe/data, read-out registers, done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx        <= '0;
      r_rd_all     <= 1'b0;
      r_wr         <= '0;
      r_clause     <= '0;
      r_len        <= '0;
      r_out_valid  <= 1'b0;
      r_out_clause <= '0;
      r_out_len    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_wr   <= '0;
      r_done <= (r_state == ST_DONE);

      if (r_state == ST_IDLE) begin
        r_idx    <= '0;
        r_rd_all <= 1'b0;
      end

      if (w_beat) begin
        r_wr     <= w_onehot;
        r_clause <= in_clause_i;
        r_len    <= in_len_i;
        if (r_idx != LAST_IDX) begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end

      if (w_rd_go) begin
        r_out_clause <= clause_i;
        r_out_len    <= w_len_sel;
        r_out_valid  <= 1'b1;
        if (r_idx == LAST_IDX) begin
          r_rd_all <= 1'b1;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef CLAUSE_LOADER_LEN_CHECK_EN
  localparam int unsigned CNT_W = $clog2(NUM_VARS + 1);

  logic [CNT_W-1:0] w_nz;
  logic             w_len_bad;
  logic             w_load_start;
  logic             r_len_err;

  // Count of nonzero 2-bit literals in the incoming clause
  always_comb begin
    w_nz = '0;
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      if (in_clause_i[2*i +: 2] != 2'b00) begin
        w_nz = w_nz + CNT_W'(1);
      end
    end
  end

  assign w_len_bad    = (32'(w_nz) != 32'(in_len_i));
  assign w_load_start = (r_state == ST_IDLE) && start_load_i;

  // Sticky error, cleared by the next accepted load request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len_err <= 1'b0;
    end else if (w_load_start) begin
      r_len_err <= 1'b0;
    end else if (w_beat && w_len_bad) begin
      r_len_err <= 1'b1;
    end
  end

  assign len_err_o = r_len_err;
`else
  assign len_err_o = 1'b0;
`endif

  assign in_ready_o   = w_in_ready;
  assign rd_o         = w_rd;
  assign wr_o         = r_wr;
  assign clause_o     = r_clause;
  assign clause_len_o = r_len;
  assign out_valid_o  = r_out_valid;
  assign out_clause_o = r_out_clause;
  assign out_len_o    = r_out_len;
  assign busy_o       = (r_state != ST_IDLE);
  assign done_o       = r_done;

endmodule
